// File: rtl/mac_operand_feeder_if.sv
// Load/control side and PE operand side of one mac_operand_feeder.
// The master modport is the feeder itself; slave is the host/PE side.
interface mac_operand_feeder_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              start;
    logic              flush;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] op_data;
    logic              op_waiting;
    logic              op_finished;
    logic              op_ready;

    modport master (
        input  wr_valid, wr_data, start, flush, op_ready,
        output wr_ready, busy, done, count, op_data, op_waiting, op_finished
    );

    modport slave (
        output wr_valid, wr_data, start, flush, op_ready,
        input  wr_ready, busy, done, count, op_data, op_waiting, op_finished
    );
endinterface

// File: rtl/mac_operand_feeder.sv
// Buffers an operand vector, then streams it element by element into one
// operand port of a systolic MAC PE using the waiting/ready/finished handshake.
module mac_operand_feeder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_operand_feeder_if.master bus
);
    localparam int               AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, STREAM, HOLD, FINISH, DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_buf [DEPTH];
    logic [DATA_W-1:0] r_op_data;
    logic              r_op_waiting;
    logic              r_op_finished;
    logic              r_busy;
    logic              r_done;

    logic              w_idle;
    logic              w_wr_accept;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_ptr_nxt;
    logic [DATA_W-1:0] w_first;

    assign w_idle      = (r_state == IDLE);
    assign w_wr_accept = w_idle && bus.wr_valid && (r_count < FULL) && !bus.flush;
    assign w_count_nxt = r_count + (w_wr_accept ? ONE : '0);
    assign w_ptr_nxt   = r_rd_ptr + ONE;
    // A write landing in the start cycle into an empty buffer is element 0.
    assign w_first     = (r_count == '0) ? bus.wr_data : r_buf[0];

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_buf[r_count[AW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_op_data     <= '0;
            r_op_waiting  <= 1'b0;
            r_op_finished <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else if (bus.flush) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_op_data     <= '0;
            r_op_waiting  <= 1'b0;
            r_op_finished <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count <= w_count_nxt;
                    if (bus.start) begin
                        r_rd_ptr <= '0;
                        r_busy   <= 1'b1;
                        if (w_count_nxt != '0) begin
                            r_state      <= STREAM;
                            r_op_data    <= w_first;
                            r_op_waiting <= 1'b1;
                        end else begin
                            r_state       <= FINISH;
                            r_op_finished <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (bus.op_ready) begin
                        r_state      <= HOLD;
                        r_op_waiting <= 1'b0;
                    end
                end
                // op_data stays put for the PE multiply cycle.
                HOLD: begin
                    if (r_rd_ptr == r_count - ONE) begin
                        r_state       <= FINISH;
                        r_op_finished <= 1'b1;
                        r_op_data     <= '0;
                    end else begin
                        r_state      <= STREAM;
                        r_rd_ptr     <= w_ptr_nxt;
                        r_op_data    <= r_buf[w_ptr_nxt[AW-1:0]];
                        r_op_waiting <= 1'b1;
                    end
                end
                // PE drops ready once it has entered its output state.
                FINISH: begin
                    if (!bus.op_ready) begin
                        r_state       <= DONE;
                        r_op_finished <= 1'b0;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_count       <= '0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready    = w_idle && (r_count < FULL);
    assign bus.count       = r_count;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.op_data     = r_op_data;
    assign bus.op_waiting  = r_op_waiting;
    assign bus.op_finished = r_op_finished;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Two feeders (A and B ports) driving a behavioural MAC PE, with a scoreboard
// of expected operands and dot-product results.
module tb_mac_operand_feeder;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_operand_feeder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ifa ();
    mac_operand_feeder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ifb ();

    mac_operand_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fa (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    mac_operand_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fb (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    // Behavioural PE: accumulates A*B per handshake, publishes on both finished.
    logic [63:0] acc, c_out;
    logic        pe_out, c_vld, stall, rnd_en, rnd_block;
    logic        w_pe_rdy;
    assign w_pe_rdy     = !pe_out && !stall && !(rnd_block && !ifa.op_finished);
    assign ifa.op_ready = w_pe_rdy;
    assign ifb.op_ready = w_pe_rdy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0; c_out <= '0; c_vld <= 1'b0; pe_out <= 1'b0; rnd_block <= 1'b0;
        end else begin
            c_vld     <= 1'b0;
            rnd_block <= rnd_en && ($urandom_range(0, 2) == 0);
            if (ifa.flush) acc <= '0;
            else if (!pe_out) begin
                if (ifa.op_waiting && ifb.op_waiting && w_pe_rdy)
                    acc <= acc + 64'(ifa.op_data) * 64'(ifb.op_data);
                if (ifa.op_finished && ifb.op_finished) begin
                    pe_out <= 1'b1; c_out <= acc; c_vld <= 1'b1;
                end
            end else if (!ifa.op_finished && !ifb.op_finished) begin
                pe_out <= 1'b0; acc <= '0;
            end
        end
    end

    // Reference model state
    logic [DATA_W-1:0] xq_a[$], xq_b[$];
    logic [63:0]       cq[$];
    logic [63:0]       exp_acc = '0;
    int mcount = 0, exp_runs = 0, n_done = 0, xfers_a = 0;
    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every transfer and result.
    logic [DATA_W-1:0] last_a, last_b;
    bit hold_a = 0, hold_b = 0;
    always @(negedge clk) begin
        if (!rst) begin
            hold_a = 0; hold_b = 0;
        end else begin
            if (hold_a) begin
                chk("a_hold_data", ifa.op_data, last_a);
                chk("a_hold_waiting", ifa.op_waiting, 0);
                hold_a = 0;
            end
            if (hold_b) begin
                chk("b_hold_data", ifb.op_data, last_b);
                chk("b_hold_waiting", ifb.op_waiting, 0);
                hold_b = 0;
            end
            if (ifa.op_waiting && ifa.op_ready) begin
                chk("a_xfer_expected", xq_a.size() > 0, 1);
                if (xq_a.size() > 0) chk("a_op_data", ifa.op_data, xq_a.pop_front());
                last_a = ifa.op_data; hold_a = 1; xfers_a++;
            end
            if (ifb.op_waiting && ifb.op_ready) begin
                chk("b_xfer_expected", xq_b.size() > 0, 1);
                if (xq_b.size() > 0) chk("b_op_data", ifb.op_data, xq_b.pop_front());
                last_b = ifb.op_data; hold_b = 1;
            end
            if (c_vld) begin
                chk("c_out_expected", cq.size() > 0, 1);
                if (cq.size() > 0) chk("c_out", c_out, cq.pop_front());
            end
            if (ifa.done) n_done++;
        end
    end

    task automatic model_wr(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (mcount < DEPTH) begin
            xq_a.push_back(a); xq_b.push_back(b);
            exp_acc += 64'(a) * 64'(b);
            mcount++;
        end
    endtask

    task automatic wr2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        ifa.wr_valid = 1'b1; ifa.wr_data = a;
        ifb.wr_valid = 1'b1; ifb.wr_data = b;
        model_wr(a, b);
        @(posedge clk); #1;
        ifa.wr_valid = 1'b0; ifb.wr_valid = 1'b0;
        chk("count", ifa.count, mcount);
        chk("wr_ready", ifa.wr_ready, mcount < DEPTH);
    endtask

    task automatic start2(input bit with_wr, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (with_wr) begin
            ifa.wr_valid = 1'b1; ifa.wr_data = a;
            ifb.wr_valid = 1'b1; ifb.wr_data = b;
            model_wr(a, b);
        end
        ifa.start = 1'b1; ifb.start = 1'b1;
        cq.push_back(exp_acc);
        exp_runs++;
        @(posedge clk); #1;
        ifa.start = 1'b0; ifb.start = 1'b0;
        ifa.wr_valid = 1'b0; ifb.wr_valid = 1'b0;
        chk("busy_after_start", ifa.busy, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!ifa.done && k < 400) begin @(negedge clk); k++; end
        chk("done_seen", ifa.done, 1);
        if (ifa.done) begin
            chk("b_done", ifb.done, 1);
            chk("busy_at_done", ifa.busy, 0);
            chk("count_at_done", ifa.count, 0);
            @(negedge clk);
            chk("done_one_cycle", ifa.done, 0);
            chk("idle_wr_ready", ifa.wr_ready, 1);
        end
        mcount = 0; exp_acc = '0;
        @(posedge clk); #1;
    endtask

    task automatic wait_xfers(input int target);
        int k = 0;
        while (xfers_a < target && k < 200) begin @(posedge clk); #1; k++; end
        chk("xfer_reached", xfers_a >= target, 1);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_waiting"}, {ifa.op_waiting, ifb.op_waiting}, 0);
        chk({nm, "_finished"}, {ifa.op_finished, ifb.op_finished}, 0);
        chk({nm, "_op_data"}, ifa.op_data | ifb.op_data, 0);
        chk({nm, "_count"}, ifa.count, 0);
        chk({nm, "_busy"}, ifa.busy, 0);
        chk({nm, "_done"}, ifa.done, 0);
    endtask

    task automatic drop_run();
        xq_a.delete(); xq_b.delete();
        void'(cq.pop_back());
        exp_runs--; mcount = 0; exp_acc = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved, base, n;
        ifa.wr_valid = 0; ifa.wr_data = '0; ifa.start = 0; ifa.flush = 0;
        ifb.wr_valid = 0; ifb.wr_data = '0; ifb.start = 0; ifb.flush = 0;
        stall = 0; rnd_en = 0;
        #12;
        check_idle("reset");
        chk("reset_wr_ready", ifa.wr_ready, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Dot product 1..4 . 5..8 = 70
        for (int i = 0; i < 4; i++) wr2(DATA_W'(i + 1), DATA_W'(i + 5));
        start2(0, '0, '0);
        wait_done();

        // Overflow: 17 writes with wr_valid held, only 0..15 kept
        for (int i = 0; i < 17; i++) wr2(DATA_W'(i), DATA_W'(1));
        chk("full_count", ifa.count, DEPTH);
        start2(0, '0, '0);
        wait_done();

        // Zero-length
        start2(0, '0, '0);
        wait_done();

        // Stall with op_data=3 for 5 cycles
        wr2(3, 2); wr2(5, 4);
        stall = 1'b1;
        start2(0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", ifa.op_data, 3);
            chk("stall_waiting", ifa.op_waiting, 1);
        end
        @(posedge clk); #1; stall = 1'b0;
        wait_done();

        // Simultaneous write and start with count=2 -> three elements
        wr2(7, 9); wr2(11, 13);
        start2(1, 17, 19);
        wait_done();

        // Flush during HOLD after the 2nd of 4 transfers
        for (int i = 0; i < 4; i++) wr2(DATA_W'(10 + i), DATA_W'(i + 1));
        base = xfers_a; saved = n_done;
        start2(0, '0, '0);
        wait_xfers(base + 2);
        ifa.flush = 1'b1; ifb.flush = 1'b1;
        @(posedge clk); #1;
        ifa.flush = 1'b0; ifb.flush = 1'b0;
        drop_run();
        check_idle("flush");
        repeat (10) @(posedge clk); #1;
        chk("flush_no_done", n_done, saved);
        chk("flush_wr_ready", ifa.wr_ready, 1);

        // Asynchronous reset mid-HOLD
        for (int i = 0; i < 4; i++) wr2(DATA_W'(20 + i), DATA_W'(3));
        base = xfers_a; saved = n_done;
        start2(0, '0, '0);
        wait_xfers(base + 1);
        rst = 1'b0;
        #1;
        drop_run();
        check_idle("rst");
        chk("rst_wr_ready", ifa.wr_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("rst_no_done", n_done, saved);

        // Randomized runs with random PE back-pressure
        rnd_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, DEPTH + 2);
            for (int i = 0; i < n; i++)
                wr2(DATA_W'($urandom_range(0, 65535)), DATA_W'($urandom_range(0, 65535)));
            start2(bit'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 65535)),
                   DATA_W'($urandom_range(0, 65535)));
            wait_done();
        end
        rnd_en = 1'b0;

        repeat (4) @(posedge clk); #1;
        chk("done_pulses", n_done, exp_runs);
        chk("operands_consumed", xq_a.size() + xq_b.size(), 0);
        chk("results_consumed", cq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
